// File: rtl/pc_fetch_if.sv
// rtl/pc_fetch_if.sv - fetch-stage bundle: imem address/data, decode feedback and IF/ID outputs
interface pc_fetch_if;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic [31:0] instr_in;
  logic [31:0] addr;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic [15:0] fetch_count;

  modport master (
    input  stall, branch_taken, branch_offset, jump, jump_target, instr_in,
    output addr, if_pc, if_instr, if_valid, fetch_count
  );

  modport slave (
    output stall, branch_taken, branch_offset, jump, jump_target, instr_in,
    input  addr, if_pc, if_instr, if_valid, fetch_count
  );
endinterface

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - program counter, imem addressing and IF/ID register with stall and redirect
module pc_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 128
) (
  input  logic         clk,
  input  logic         rst,
  pc_fetch_if.master   bus
);

  localparam logic [31:0] ADDR_MASK = 32'(IMEM_BYTES - 1);

  logic [31:0] pc;
  logic [31:0] if_pc_q;
  logic [31:0] if_instr_q;
  logic        if_valid_q;
  logic [15:0] fetch_count_q;

  logic [31:0] if_pc_plus4;
  logic [31:0] br_target;
  logic [31:0] jmp_target;
  logic [31:0] redirect_target;
  logic        redirect;

  // Targets are computed from the instruction sitting in IF/ID, not from pc.
  assign if_pc_plus4     = if_pc_q + 32'd4;
  assign br_target       = if_pc_plus4 + {{14{bus.branch_offset[15]}}, bus.branch_offset, 2'b00};
  assign jmp_target      = {if_pc_plus4[31:28], bus.jump_target, 2'b00};
  assign redirect        = if_valid_q && (bus.jump || bus.branch_taken);
  assign redirect_target = bus.jump ? jmp_target : br_target;

  // Only the memory address wraps; pc keeps counting in full.
  assign bus.addr        = pc & ADDR_MASK;
  assign bus.if_pc       = if_pc_q;
  assign bus.if_instr    = if_instr_q;
  assign bus.if_valid    = if_valid_q;
  assign bus.fetch_count = fetch_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc            <= RESET_PC;
      if_pc_q       <= 32'h0;
      if_instr_q    <= 32'h0;
      if_valid_q    <= 1'b0;
      fetch_count_q <= 16'h0;
    end else if (redirect) begin
      pc         <= redirect_target;
      if_pc_q    <= 32'h0;
      if_instr_q <= 32'h0;
      if_valid_q <= 1'b0;
    end else if (!bus.stall) begin
      pc            <= pc + 32'd4;
      if_pc_q       <= pc;
      if_instr_q    <= bus.instr_in;
      if_valid_q    <= 1'b1;
      fetch_count_q <= fetch_count_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - directed vector bench for pc_fetch with a combinational imem model
module tb_pc_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [31:0] mem [0:31];

  pc_fetch_if bus();

  pc_fetch #(.RESET_PC(32'h0), .IMEM_BYTES(128)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.instr_in = mem[bus.addr[6:2]];

  typedef struct {
    logic        stall;
    logic        br;
    logic [15:0] off;
    logic        jmp;
    logic [25:0] jt;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_valid;
    logic [15:0] e_fc;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] a, input logic [31:0] p,
                         input logic [31:0] ins, input logic v, input logic [15:0] fc);
    chk({tag, " addr"},        bus.addr, a);
    chk({tag, " if_pc"},       bus.if_pc, p);
    chk({tag, " if_instr"},    bus.if_instr, ins);
    chk({tag, " if_valid"},    32'(bus.if_valid), 32'(v));
    chk({tag, " fetch_count"}, 32'(bus.fetch_count), 32'(fc));
  endtask

  task automatic drive(input logic s, input logic b, input logic [15:0] o,
                       input logic j, input logic [25:0] t);
    bus.stall         = s;
    bus.branch_taken  = b;
    bus.branch_offset = o;
    bus.jump          = j;
    bus.jump_target   = t;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + 32'(i);
    mem[0] = 32'h0000_0000;
    mem[1] = 32'h3402_0026;
    mem[3] = 32'h0062_8020;

    //           stall br off       jmp jt     addr   if_pc  if_instr       v  fc
    vecs[0]  = '{1'b0, 1'b0, 16'h0,    1'b0, 26'h0,  32'h04, 32'h00, 32'h0000_0000, 1'b1, 16'd1};
    vecs[1]  = '{1'b0, 1'b0, 16'h0,    1'b0, 26'h0,  32'h08, 32'h04, 32'h3402_0026, 1'b1, 16'd2};
    vecs[2]  = '{1'b0, 1'b0, 16'h0,    1'b0, 26'h0,  32'h0C, 32'h08, 32'hA000_0002, 1'b1, 16'd3};
    vecs[3]  = '{1'b1, 1'b0, 16'h0,    1'b0, 26'h0,  32'h0C, 32'h08, 32'hA000_0002, 1'b1, 16'd3};
    vecs[4]  = '{1'b1, 1'b0, 16'h0,    1'b0, 26'h0,  32'h0C, 32'h08, 32'hA000_0002, 1'b1, 16'd3};
    vecs[5]  = '{1'b1, 1'b0, 16'h0,    1'b0, 26'h0,  32'h0C, 32'h08, 32'hA000_0002, 1'b1, 16'd3};
    vecs[6]  = '{1'b0, 1'b0, 16'h0,    1'b0, 26'h0,  32'h10, 32'h0C, 32'h0062_8020, 1'b1, 16'd4};
    vecs[7]  = '{1'b0, 1'b0, 16'h0,    1'b0, 26'h0,  32'h14, 32'h10, 32'hA000_0004, 1'b1, 16'd5};
    vecs[8]  = '{1'b0, 1'b0, 16'h0,    1'b0, 26'h0,  32'h18, 32'h14, 32'hA000_0005, 1'b1, 16'd6};
    vecs[9]  = '{1'b0, 1'b1, 16'hFFFD, 1'b0, 26'h0,  32'h0C, 32'h00, 32'h0000_0000, 1'b0, 16'd6};
    vecs[10] = '{1'b0, 1'b0, 16'h0,    1'b0, 26'h0,  32'h10, 32'h0C, 32'h0062_8020, 1'b1, 16'd7};
    vecs[11] = '{1'b1, 1'b0, 16'h0,    1'b1, 26'h3,  32'h0C, 32'h00, 32'h0000_0000, 1'b0, 16'd7};
    vecs[12] = '{1'b1, 1'b0, 16'h0,    1'b0, 26'h0,  32'h0C, 32'h00, 32'h0000_0000, 1'b0, 16'd7};
    vecs[13] = '{1'b0, 1'b0, 16'h0,    1'b1, 26'h3,  32'h10, 32'h0C, 32'h0062_8020, 1'b1, 16'd8};
    vecs[14] = '{1'b0, 1'b1, 16'h0010, 1'b1, 26'h5,  32'h14, 32'h00, 32'h0000_0000, 1'b0, 16'd8};
    vecs[15] = '{1'b0, 1'b1, 16'h0010, 1'b0, 26'h0,  32'h18, 32'h14, 32'hA000_0005, 1'b1, 16'd9};
    vecs[16] = '{1'b0, 1'b1, 16'h0002, 1'b0, 26'h0,  32'h20, 32'h00, 32'h0000_0000, 1'b0, 16'd9};
    vecs[17] = '{1'b0, 1'b0, 16'h0,    1'b0, 26'h0,  32'h24, 32'h20, 32'hA000_0008, 1'b1, 16'd10};

    drive(1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
    #12;
    chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].stall, vecs[i].br, vecs[i].off, vecs[i].jmp, vecs[i].jt);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_pc, vecs[i].e_instr,
              vecs[i].e_valid, vecs[i].e_fc);
    end

    // Jump near the top of memory so pc crosses IMEM_BYTES.
    drive(1'b0, 1'b0, 16'h0, 1'b1, 26'h1F);
    @(posedge clk); #1;
    chk_all("jmp7c", 32'h7C, 32'h0, 32'h0, 1'b0, 16'd10);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
    @(posedge clk); #1;
    chk_all("wrap0", 32'h00, 32'h7C, 32'hA000_001F, 1'b1, 16'd11);
    @(posedge clk); #1;
    chk_all("wrap1", 32'h04, 32'h80, 32'h0000_0000, 1'b1, 16'd12);

    // Branch from 0x80 to 0x88, then reset asynchronously before the next edge.
    drive(1'b0, 1'b1, 16'h0001, 1'b0, 26'h0);
    @(posedge clk); #1;
    chk_all("br88", 32'h08, 32'h0, 32'h0, 1'b0, 16'd12);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
    #1 rst = 1'b1;
    #1;
    chk_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk_all("post_rst", 32'h04, 32'h0, 32'h0, 1'b1, 16'd1);
    @(posedge clk); #1;
    chk_all("post_rst2", 32'h08, 32'h04, 32'h3402_0026, 1'b1, 16'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
